// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - shared types, default constants and x-wrap helper for the object scheduler
package obj_pkg;

    localparam int DEF_OBJ_SIZE       = 40;
    localparam int DEF_FIELD_H        = 480;
    localparam int DEF_X_LIMIT        = 600;
    localparam int DEF_STEP1          = 2;
    localparam int DEF_STEP2          = 3;
    localparam int DEF_X_HOP          = 173;
    localparam int DEF_RESPAWN_FRAMES = 60;
    localparam int DEF_X1_INIT        = 100;
    localparam int DEF_X2_INIT        = 400;
    localparam int DEF_MAX_MISS       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_UPD1,
        ST_UPD2,
        ST_OVER
    } obj_state_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        end_show;
        logic [7:0]  respawn;
    } obj_t;

    // Advance x by the hop distance, folding back into the playfield width
    function automatic logic [11:0] wrap_x(input logic [11:0] x,
                                           input logic [11:0] hop,
                                           input logic [11:0] limit);
        logic [11:0] sum;
        sum = x + hop;
        return (sum >= limit) ? (sum - limit) : sum;
    endfunction

endpackage

// File: rtl/obj_updater.sv
// rtl/obj_updater.sv - combinational next-state of one falling object (hit, bottom wrap, respawn)
module obj_updater import obj_pkg::*; #(
    parameter int OBJ_SIZE       = DEF_OBJ_SIZE,
    parameter int FIELD_H        = DEF_FIELD_H,
    parameter int X_LIMIT        = DEF_X_LIMIT,
    parameter int X_HOP          = DEF_X_HOP,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  obj_t        cur,
    input  logic [11:0] step,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    output obj_t        nxt,
    output logic        hit,
    output logic        miss
);

    localparam logic [11:0] SIZE   = 12'(OBJ_SIZE);
    localparam logic [11:0] BOTTOM = 12'(FIELD_H - OBJ_SIZE);

    logic [11:0] ny;
    logic        overlap;

    assign ny      = cur.y + step;
    assign overlap = (cur.x < player_x + SIZE) && (player_x < cur.x + SIZE) &&
                     (ny < player_y + SIZE) && (player_y < ny + SIZE);

    // Visible objects fall (hit beats bottom); hidden ones count down to respawn
    always_comb begin
        nxt  = cur;
        hit  = 1'b0;
        miss = 1'b0;
        if (!cur.end_show) begin
            if (overlap) begin
                hit          = 1'b1;
                nxt.end_show = 1'b1;
                nxt.y        = ny;
                nxt.respawn  = 8'(RESPAWN_FRAMES);
            end else if (ny >= BOTTOM) begin
                miss  = 1'b1;
                nxt.y = 12'd0;
            end else begin
                nxt.y = ny;
            end
        end else begin
            if (cur.respawn != 8'd0) begin
                nxt.respawn = cur.respawn - 8'd1;
            end
            if (cur.respawn == 8'd1) begin
                nxt.end_show = 1'b0;
                nxt.y        = 12'd0;
                nxt.x        = wrap_x(cur.x, 12'(X_HOP), 12'(X_LIMIT));
            end
        end
    end

endmodule

// File: rtl/obj_scheduler.sv
// rtl/obj_scheduler.sv - per-frame scheduler for two falling objects sharing one updater
module obj_scheduler import obj_pkg::*; #(
    parameter int OBJ_SIZE       = DEF_OBJ_SIZE,
    parameter int FIELD_H        = DEF_FIELD_H,
    parameter int X_LIMIT        = DEF_X_LIMIT,
    parameter int STEP1          = DEF_STEP1,
    parameter int STEP2          = DEF_STEP2,
    parameter int X_HOP          = DEF_X_HOP,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int X1_INIT        = DEF_X1_INIT,
    parameter int X2_INIT        = DEF_X2_INIT,
    parameter int MAX_MISS       = DEF_MAX_MISS
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        frame_sync,
    input  logic        start,
    input  logic [11:0] player_x,
    input  logic [11:0] player_y,
    output logic [11:0] obj1_x_begin,
    output logic [11:0] obj1_y_begin,
    output logic [11:0] obj2_x_begin,
    output logic [11:0] obj2_y_begin,
    output logic        end_show1,
    output logic        end_show2,
    output logic [7:0]  score,
    output logic        game_over
);

    obj_state_t  state;
    obj_t        obj1, obj2;
    obj_t        upd_cur, upd_nxt;
    logic [11:0] upd_step;
    logic        upd_hit, upd_miss;
    logic [3:0]  misses;
    logic        sync_d;
    logic        tick;
    logic        miss_limit;
    logic [7:0]  score_inc;

    assign tick       = sync_d & ~frame_sync;
    assign score_inc  = (score == 8'hFF) ? score : score + 8'd1;
    assign miss_limit = upd_miss && ((misses + 4'd1) >= 4'(MAX_MISS));

    // Route the object owned by the current update state into the shared updater
    always_comb begin
        upd_cur  = obj1;
        upd_step = 12'(STEP1);
        if (state == ST_UPD2) begin
            upd_cur  = obj2;
            upd_step = 12'(STEP2);
        end
    end

    obj_updater #(
        .OBJ_SIZE      (OBJ_SIZE),
        .FIELD_H       (FIELD_H),
        .X_LIMIT       (X_LIMIT),
        .X_HOP         (X_HOP),
        .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_updater (
        .cur     (upd_cur),
        .step    (upd_step),
        .player_x(player_x),
        .player_y(player_y),
        .nxt     (upd_nxt),
        .hit     (upd_hit),
        .miss    (upd_miss)
    );

    // Game FSM: start, frame tick, two update slots, game over; owns all registered outputs
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state     <= ST_IDLE;
            obj1      <= '{x: 12'(X1_INIT), y: 12'd0, end_show: 1'b1, respawn: 8'd0};
            obj2      <= '{x: 12'(X2_INIT), y: 12'd0, end_show: 1'b1, respawn: 8'd0};
            score     <= 8'd0;
            game_over <= 1'b0;
            misses    <= 4'd0;
            sync_d    <= 1'b1;
        end else begin
            sync_d <= frame_sync;
            unique case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        obj1      <= '{x: 12'(X1_INIT), y: 12'd0, end_show: 1'b0, respawn: 8'd0};
                        obj2      <= '{x: 12'(X2_INIT), y: 12'd0, end_show: 1'b0, respawn: 8'd0};
                        score     <= 8'd0;
                        game_over <= 1'b0;
                        misses    <= 4'd0;
                        state     <= ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (tick) state <= ST_UPD1;
                end
                ST_UPD1: begin
                    obj1  <= upd_nxt;
                    state <= ST_UPD2;
                end
                ST_UPD2: begin
                    obj2 <= upd_nxt;
                    // obj2 still gets its update in the frame that ends the game
                    if (game_over || miss_limit) begin
                        obj1.end_show <= 1'b1;
                        obj2.end_show <= 1'b1;
                        state         <= ST_OVER;
                    end else begin
                        state <= ST_WAIT_FRAME;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (state == ST_UPD1 || state == ST_UPD2) begin
                if (upd_hit) score <= score_inc;
                if (upd_miss) begin
                    misses <= misses + 4'd1;
                    if (miss_limit) game_over <= 1'b1;
                end
            end
        end
    end

    assign obj1_x_begin = obj1.x;
    assign obj1_y_begin = obj1.y;
    assign obj2_x_begin = obj2.x;
    assign obj2_y_begin = obj2.y;
    assign end_show1    = obj1.end_show;
    assign end_show2    = obj2.end_show;

endmodule

// File: tb/tb_obj_scheduler.sv
// tb/tb_obj_scheduler.sv - randomized self-checking bench for obj_scheduler against a frame-level model
module tb_obj_scheduler;

    logic        clk_vga = 1'b0;
    logic        rst, frame_sync, start;
    logic [11:0] player_x, player_y;
    logic [11:0] obj1_x_begin, obj1_y_begin, obj2_x_begin, obj2_y_begin;
    logic        end_show1, end_show2, game_over;
    logic [7:0]  score;

    int n_checks = 0;
    int n_errors = 0;

    // frame-level reference state
    int m_x[2], m_y[2], m_cnt[2];
    bit m_hid[2];
    int m_score, m_miss;
    bit m_run, m_over;

    always #5 clk_vga = ~clk_vga;

    obj_scheduler dut (
        .clk_vga     (clk_vga),
        .rst         (rst),
        .frame_sync  (frame_sync),
        .start       (start),
        .player_x    (player_x),
        .player_y    (player_y),
        .obj1_x_begin(obj1_x_begin),
        .obj1_y_begin(obj1_y_begin),
        .obj2_x_begin(obj2_x_begin),
        .obj2_y_begin(obj2_y_begin),
        .end_show1   (end_show1),
        .end_show2   (end_show2),
        .score       (score),
        .game_over   (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_x[0] = 100; m_x[1] = 400;
        m_y[0] = 0;   m_y[1] = 0;
        m_hid[0] = 1; m_hid[1] = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_score = 0; m_miss = 0; m_run = 0; m_over = 0;
    endfunction

    function automatic void m_start();
        if (!m_run) begin
            m_x[0] = 100; m_x[1] = 400;
            m_y[0] = 0;   m_y[1] = 0;
            m_hid[0] = 0; m_hid[1] = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_score = 0; m_miss = 0; m_over = 0; m_run = 1;
        end
    endfunction

    function automatic void m_frame(input int px, input int py);
        bit ending;
        int ny;
        ending = 0;
        if (!m_run) return;
        for (int i = 0; i < 2; i++) begin
            ny = m_y[i] + ((i == 0) ? 2 : 3);
            if (!m_hid[i]) begin
                if (m_x[i] < px + 40 && px < m_x[i] + 40 && ny < py + 40 && py < ny + 40) begin
                    m_hid[i] = 1;
                    m_y[i]   = ny;
                    m_cnt[i] = 60;
                    if (m_score < 255) m_score++;
                end else if (ny >= 440) begin
                    m_y[i] = 0;
                    m_miss++;
                    if (m_miss >= 3) ending = 1;
                end else begin
                    m_y[i] = ny;
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_hid[i] = 0;
                    m_y[i]   = 0;
                    m_x[i]   = (m_x[i] + 173) % 600;
                end
            end
        end
        if (ending) begin
            m_run = 0; m_over = 1;
            m_hid[0] = 1; m_hid[1] = 1;
        end
    endfunction

    function automatic logic [23:0] m_pos(input int i);
        return {12'(m_x[i]), 12'(m_y[i])};
    endfunction

    task automatic check_all();
        check("obj1_pos", {obj1_x_begin, obj1_y_begin}, m_pos(0));
        check("obj2_pos", {obj2_x_begin, obj2_y_begin}, m_pos(1));
        check("end_show", {end_show1, end_show2}, {m_hid[0], m_hid[1]});
        check("score", score, m_score);
        check("game_over", game_over, m_over);
    endtask

    // One vsync pulse, three samples low; checks obj1 moves 2 edges in, obj2 3 edges in
    task automatic do_frame();
        logic [23:0] p1_old, p2_old, p1_new;
        p1_old = m_pos(0);
        p2_old = m_pos(1);
        m_frame(int'(player_x), int'(player_y));
        p1_new = m_pos(0);
        frame_sync = 1'b0;
        @(negedge clk_vga);
        check("obj1_hold", {obj1_x_begin, obj1_y_begin}, p1_old);
        @(negedge clk_vga);
        check("obj1_upd", {obj1_x_begin, obj1_y_begin}, p1_new);
        check("obj2_hold", {obj2_x_begin, obj2_y_begin}, p2_old);
        @(negedge clk_vga);
        frame_sync = 1'b1;
        check_all();
        @(negedge clk_vga);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_vga);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_vga);
        start = 1'b0;
        m_start();
    endtask

    task automatic target_visible();
        if (!m_hid[0]) begin
            player_x = 12'(m_x[0]); player_y = 12'(m_y[0]);
        end else if (!m_hid[1]) begin
            player_x = 12'(m_x[1]); player_y = 12'(m_y[1]);
        end else begin
            player_x = 12'd600; player_y = 12'd0;
        end
    endtask

    initial begin
        int px, py, k;
        rst = 1'b1; frame_sync = 1'b1; start = 1'b0;
        player_x = 12'd600; player_y = 12'd0;
        @(negedge clk_vga);
        @(negedge clk_vga);
        rst = 1'b0;
        m_reset();
        check("rst_x1", obj1_x_begin, 100);
        check("rst_x2", obj2_x_begin, 400);
        check("rst_es", {end_show1, end_show2}, 2'b11);
        check("rst_score", score, 0);
        check_all();
        repeat (10) do_frame();

        // start held high across several frames acts only once
        start = 1'b1;
        @(negedge clk_vga);
        m_start();
        check_all();
        repeat (5) do_frame();
        start = 1'b0;
        check("y1_5f", obj1_y_begin, 10);
        check("y2_5f", obj2_y_begin, 15);

        // hit on first frame, then respawn after 60 hidden frames
        do_reset();
        pulse_start();
        player_x = 12'd100; player_y = 12'd20;
        do_frame();
        check("hit_es1", end_show1, 1);
        check("hit_score", score, 1);
        player_x = 12'd600; player_y = 12'd0;
        repeat (59) do_frame();
        check("still_hidden", end_show1, 1);
        do_frame();
        check("respawn_x", obj1_x_begin, 273);
        check("respawn_y", obj1_y_begin, 0);
        check("respawn_es", end_show1, 0);

        // three wraps end the game; outputs freeze; start restarts
        for (int f = 0; f < 600 && m_run; f++) do_frame();
        check("over_flag", game_over, 1);
        check("over_es", {end_show1, end_show2}, 2'b11);
        repeat (3) do_frame();
        pulse_start();
        check("restart_score", score, 0);
        check("restart_go", game_over, 0);
        check_all();

        // random player placement, often near an object
        for (int f = 0; f < 400; f++) begin
            if (!m_run) pulse_start();
            k = int'($urandom_range(0, 2));
            if (k == 0) begin
                px = int'($urandom_range(0, 640));
                py = int'($urandom_range(0, 480));
            end else begin
                px = m_x[k-1] + int'($urandom_range(0, 70)) - 35;
                py = m_y[k-1] + int'($urandom_range(0, 70)) - 35;
            end
            if (px < 0) px = 0;
            if (px > 640) px = 640;
            if (py < 0) py = 0;
            if (py > 480) py = 480;
            player_x = 12'(px);
            player_y = 12'(py);
            do_frame();
        end

        // score saturation through repeated hits
        do_reset();
        pulse_start();
        for (int f = 0; f < 9000 && m_score < 255; f++) begin
            target_visible();
            do_frame();
        end
        check("sat_score", score, 255);
        for (int f = 0; f < 130; f++) begin
            target_visible();
            do_frame();
        end
        check("sat_hold", score, 255);

        // reset the cycle after the tick: no obj2 update follows
        player_x = 12'd600; player_y = 12'd0;
        frame_sync = 1'b0;
        @(negedge clk_vga);
        rst = 1'b1;
        @(negedge clk_vga);
        rst = 1'b0;
        frame_sync = 1'b1;
        m_reset();
        check("midrst_x1", obj1_x_begin, 100);
        check("midrst_y2", obj2_y_begin, 0);
        check_all();
        @(negedge clk_vga);
        check_all();
        do_frame();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
